// File: rtl/tetron_collision_checker.sv
// tetron_collision_checker: walks the four blocks of a tetromino placed at an
// anchor cell, checking each block against the board bounds and, for in-bounds
// cells, against board occupancy read through a one-cycle-latency port.
// Optional feature macro: TETRON_EARLY_EXIT_EN -- when defined, the walk stops at
// the first colliding block instead of always visiting all four.
module tetron_collision_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] anchor_row,
    input  logic [4:0] anchor_col,
    input  logic [4:0] blk1_voffset,
    input  logic [4:0] blk1_hoffset,
    input  logic [4:0] blk2_voffset,
    input  logic [4:0] blk2_hoffset,
    input  logic [4:0] blk3_voffset,
    input  logic [4:0] blk3_hoffset,
    input  logic [4:0] blk4_voffset,
    input  logic [4:0] blk4_hoffset,
    output logic       busy,
    output logic       done,
    output logic       collide,
    output logic       oob,
    output logic       rd_en,
    output logic [4:0] rd_row,
    output logic [4:0] rd_col,
    input  logic       rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EVAL,
        S_DONE
    } state_t;

    // Six-bit limits so a board dimension of 32 still compares correctly.
    localparam logic [5:0] H_LIM = 6'(BOARD_H);
    localparam logic [5:0] W_LIM = 6'(BOARD_W);

    state_t     state_q, state_d;
    logic [1:0] k_q, k_d;              // block index, encoded as block number - 1
    logic [4:0] anchor_row_q, anchor_row_d;
    logic [4:0] anchor_col_q, anchor_col_d;
    logic [4:0] voff_q [4];
    logic [4:0] voff_d [4];
    logic [4:0] hoff_q [4];
    logic [4:0] hoff_d [4];
    logic       cell_oob_q, cell_oob_d; // current block was out of bounds at issue
    logic       collide_q, collide_d;
    logic       oob_q, oob_d;

    logic [4:0] in_voff [4];
    logic [4:0] in_hoff [4];
    logic [4:0] cell_row [4];
    logic [4:0] cell_col [4];
    logic       cell_out [4];
    logic [4:0] cur_row;
    logic [4:0] cur_col;
    logic       cur_out;
    logic       hit;

    assign in_voff[0] = blk1_voffset;
    assign in_voff[1] = blk2_voffset;
    assign in_voff[2] = blk3_voffset;
    assign in_voff[3] = blk4_voffset;
    assign in_hoff[0] = blk1_hoffset;
    assign in_hoff[1] = blk2_hoffset;
    assign in_hoff[2] = blk3_hoffset;
    assign in_hoff[3] = blk4_hoffset;

    // Per-block cell coordinates (modulo 32) and bounds test; negative sums wrap
    // to large values and therefore land out of bounds naturally.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cell
            assign cell_row[gi] = anchor_row_q + voff_q[gi];
            assign cell_col[gi] = anchor_col_q + hoff_q[gi];
            assign cell_out[gi] = ({1'b0, cell_row[gi]} >= H_LIM) ||
                                  ({1'b0, cell_col[gi]} >= W_LIM);
        end
    endgenerate

    assign cur_row = cell_row[k_q];
    assign cur_col = cell_col[k_q];
    assign cur_out = cell_out[k_q];
    assign hit     = cell_oob_q || rd_data;

    // Next-state and datapath update for the block walk.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        anchor_row_d = anchor_row_q;
        anchor_col_d = anchor_col_q;
        cell_oob_d   = cell_oob_q;
        collide_d    = collide_q;
        oob_d        = oob_q;
        for (int i = 0; i < 4; i++) begin
            voff_d[i] = voff_q[i];
            hoff_d[i] = hoff_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    anchor_row_d = anchor_row;
                    anchor_col_d = anchor_col;
                    for (int i = 0; i < 4; i++) begin
                        voff_d[i] = in_voff[i];
                        hoff_d[i] = in_hoff[i];
                    end
                    collide_d  = 1'b0;
                    oob_d      = 1'b0;
                    cell_oob_d = 1'b0;
                    k_d        = 2'd0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cell_oob_d = cur_out;
                state_d    = S_EVAL;
            end
            S_EVAL: begin
                if (cell_oob_q) begin
                    oob_d = 1'b1;
                end
                if (hit) begin
                    collide_d = 1'b1;
                end
                if (k_q == 2'd3) begin
                    state_d = S_DONE;
`ifdef TETRON_EARLY_EXIT_EN
                end else if (hit) begin
                    state_d = S_DONE;
`endif
                end else begin
                    k_d     = 2'(k_q + 2'd1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                k_d     = 2'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-operand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            anchor_row_q <= 5'd0;
            anchor_col_q <= 5'd0;
            cell_oob_q   <= 1'b0;
            collide_q    <= 1'b0;
            oob_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                voff_q[i] <= 5'd0;
                hoff_q[i] <= 5'd0;
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            anchor_row_q <= anchor_row_d;
            anchor_col_q <= anchor_col_d;
            cell_oob_q   <= cell_oob_d;
            collide_q    <= collide_d;
            oob_q        <= oob_d;
            for (int i = 0; i < 4; i++) begin
                voff_q[i] <= voff_d[i];
                hoff_q[i] <= hoff_d[i];
            end
        end
    end

    // Status and read-port outputs; the read address is forced to zero when idle.
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        collide = collide_q;
        oob     = oob_q;
        rd_en   = (state_q == S_ISSUE) && !cur_out;
        rd_row  = rd_en ? cur_row : 5'd0;
        rd_col  = rd_en ? cur_col : 5'd0;
    end

endmodule

// File: tb/tb_tetron_collision_checker.sv
// Bench for tetron_collision_checker: table of directed placements, random
// placements checked against a block-walk reference model, plus start-repeat
// and mid-check reset sequences. Honours TETRON_EARLY_EXIT_EN like the design.
module tb_tetron_collision_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] anchor_row = 5'd0;
    logic [4:0] anchor_col = 5'd0;
    logic [4:0] voff [4];
    logic [4:0] hoff [4];
    logic       busy, done, collide, oob, rd_en;
    logic [4:0] rd_row, rd_col;
    logic       rd_data = 1'b0;

    bit board [32][32];

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]       ar;
        logic [4:0]       ac;
        logic [3:0][4:0]  v;
        logic [3:0][4:0]  h;
        bit               occ_en;
        logic [4:0]       occ_r;
        logic [4:0]       occ_c;
        int               exp_col;
        int               exp_oob;
        int               exp_done;
    } vec_t;

    vec_t vecs [8];

    // model results
    int m_col, m_oob, m_done;
    int m_reads [$];

    tetron_collision_checker #(.BOARD_W(10), .BOARD_H(20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .anchor_row(anchor_row), .anchor_col(anchor_col),
        .blk1_voffset(voff[0]), .blk1_hoffset(hoff[0]),
        .blk2_voffset(voff[1]), .blk2_hoffset(hoff[1]),
        .blk3_voffset(voff[2]), .blk3_hoffset(hoff[2]),
        .blk4_voffset(voff[3]), .blk4_hoffset(hoff[3]),
        .busy(busy), .done(done), .collide(collide), .oob(oob),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // board memory with one-cycle read latency
    always @(posedge clk) begin
        rd_data <= rd_en ? board[rd_row][rd_col] : 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t make_vec(input int ar, input int ac,
                                      input int v1, input int h1, input int v2, input int h2,
                                      input int v3, input int h3, input int v4, input int h4,
                                      input bit occ_en, input int occ_r, input int occ_c,
                                      input int ecol, input int eoob,
                                      input int done_full, input int done_early);
        vec_t t;
        t.ar = 5'(ar); t.ac = 5'(ac);
        t.v[0] = 5'(v1); t.h[0] = 5'(h1);
        t.v[1] = 5'(v2); t.h[1] = 5'(h2);
        t.v[2] = 5'(v3); t.h[2] = 5'(h3);
        t.v[3] = 5'(v4); t.h[3] = 5'(h4);
        t.occ_en = occ_en; t.occ_r = 5'(occ_r); t.occ_c = 5'(occ_c);
        t.exp_col = ecol; t.exp_oob = eoob;
`ifdef TETRON_EARLY_EXIT_EN
        t.exp_done = done_early;
`else
        t.exp_done = done_full;
`endif
        return t;
    endfunction

    // Reference: visit blocks in order; block b is looked up in cycle 2b-1.
    function automatic void model(input vec_t t);
        int r, c;
        bit out;
        m_col = 0; m_oob = 0; m_done = 9;
        m_reads.delete();
        for (int b = 1; b <= 4; b++) begin
            r = (int'(t.ar) + int'(t.v[b-1])) % 32;
            c = (int'(t.ac) + int'(t.h[b-1])) % 32;
            out = (r >= 20) || (c >= 10);
            if (out) begin
                m_oob = 1; m_col = 1;
            end else begin
                m_reads.push_back((2*b-1)*1024 + r*32 + c);
                if (board[r][c]) m_col = 1;
            end
`ifdef TETRON_EARLY_EXIT_EN
            if (m_col == 1) begin
                m_done = 2*b + 1;
                break;
            end
`endif
        end
    endfunction

    task automatic set_board(input vec_t t);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                board[r][c] = 1'b0;
        if (t.occ_en) board[t.occ_r][t.occ_c] = 1'b1;
    endtask

    task automatic run_vec(input vec_t t, input bit rep, input string tag);
        int act_reads [$];
        int done_cyc = -1;
        int ndone = 0;
        int proto_err = 0;
        int col_at_done = -1;
        int oob_at_done = -1;
        bit reads_ok;
        set_board(t);
        model(t);
        @(negedge clk);
        anchor_row = t.ar; anchor_col = t.ac;
        for (int i = 0; i < 4; i++) begin
            voff[i] = t.v[i]; hoff[i] = t.h[i];
        end
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            if (rep && cyc <= 8) begin
                start = 1'b1;
                anchor_row = t.ar ^ 5'd3;
                anchor_col = t.ac ^ 5'd5;
                voff[0] = t.v[0] ^ 5'd1;
            end else begin
                start = 1'b0;
            end
            if (done_cyc < 0 && !busy) proto_err++;
            if (done_cyc > 0 && busy) proto_err++;
            if (rd_en) act_reads.push_back(cyc*1024 + int'(rd_row)*32 + int'(rd_col));
            else if (rd_row != 5'd0 || rd_col != 5'd0) proto_err++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    col_at_done = int'(collide);
                    oob_at_done = int'(oob);
                end
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
        end
        reads_ok = (act_reads.size() == m_reads.size());
        if (reads_ok)
            foreach (m_reads[i]) if (act_reads[i] != m_reads[i]) reads_ok = 0;
        chk({tag, " done_cycle"}, done_cyc, t.exp_done);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " collide"}, col_at_done, t.exp_col);
        chk({tag, " oob"}, oob_at_done, t.exp_oob);
        chk({tag, " collide_held"}, int'(collide), t.exp_col);
        chk({tag, " oob_held"}, int'(oob), t.exp_oob);
        chk({tag, " reads"}, int'(reads_ok), 1);
        chk({tag, " protocol_errs"}, proto_err, 0);
        $display("%s: anchor=(%0d,%0d) done_cycle=%0d collide=%0d oob=%0d reads=%0d",
                 tag, t.ar, t.ac, done_cyc, col_at_done, oob_at_done, act_reads.size());
    endtask

    task automatic reset_mid_check(input vec_t t);
        int ndone = 0;
        set_board(t);
        @(negedge clk);
        anchor_row = t.ar; anchor_col = t.ac;
        for (int i = 0; i < 4; i++) begin
            voff[i] = t.v[i]; hoff[i] = t.h[i];
        end
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
            if (cyc == 4) rst = 1'b1;
            if (cyc == 5) begin
                rst = 1'b0;
                chk("rst_mid busy", int'(busy), 0);
                chk("rst_mid outputs", int'({done, collide, oob, rd_en, rd_row, rd_col}), 0);
            end
        end
        chk("rst_mid no_done", ndone, 0);
        $display("reset_mid_check: done pulses after abort=%0d", ndone);
    endtask

    initial begin
        vec_t t;
        int sel [5] = '{0, 1, 2, 30, 31};
        for (int i = 0; i < 4; i++) begin
            voff[i] = 5'd0; hoff[i] = 5'd0;
        end

        //                  ar ac  v1 h1  v2 h2  v3 h3  v4 h4 occ r  c  col oob full early
        vecs[0] = make_vec( 5, 4,  0, 0,  0, 1,  0,31,  1, 0, 0, 0, 0,  0, 0,  9, 9);
        vecs[1] = make_vec( 5, 0,  0, 0,  0, 1,  0,31,  1, 0, 0, 0, 0,  1, 1,  9, 7);
        vecs[2] = make_vec( 5, 4,  0, 0,  0, 1,  0,31,  1, 0, 1, 5, 5,  1, 0,  9, 5);
        vecs[3] = make_vec(19, 4,  0, 0,  0, 1,  0,31,  1, 0, 0, 0, 0,  1, 1,  9, 9);
        vecs[4] = make_vec( 0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0,  9, 9);
        vecs[5] = make_vec( 0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 1, 0, 0,  1, 0,  9, 3);
        vecs[6] = make_vec( 2, 9,  0, 0,  0, 1,  1, 0,  0,31, 0, 0, 0,  1, 1,  9, 5);
        vecs[7] = make_vec(10, 2,  0, 0,  0, 1,  0,31,  1, 0, 1,11, 2,  1, 0,  9, 9);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset collide", int'(collide), 0);
        chk("reset oob", int'(oob), 0);
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset rd_addr", int'({rd_row, rd_col}), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0, $sformatf("table%0d", i));

        run_vec(vecs[0], 1'b1, "start_repeat");
        reset_mid_check(vecs[0]);
        run_vec(vecs[0], 1'b0, "after_reset");
        run_vec(vecs[2], 1'b0, "after_reset_occ");

        for (int n = 0; n < 40; n++) begin
            t = make_vec($urandom_range(0, 22), $urandom_range(0, 12),
                         sel[$urandom_range(0, 4)], sel[$urandom_range(0, 4)],
                         sel[$urandom_range(0, 4)], sel[$urandom_range(0, 4)],
                         sel[$urandom_range(0, 4)], sel[$urandom_range(0, 4)],
                         sel[$urandom_range(0, 4)], sel[$urandom_range(0, 4)],
                         1'($urandom_range(0, 1)), $urandom_range(0, 21), $urandom_range(0, 11),
                         0, 0, 9, 9);
            set_board(t);
            model(t);
            t.exp_col = m_col; t.exp_oob = m_oob; t.exp_done = m_done;
            run_vec(t, 1'b0, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tetron_collision_checker.md
TETRON_COLLISION_CHECKER -- requirements
Module: tetron_collision_checker

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board width in cells.
REQ-002 SHALL have parameter BOARD_H, default 20, board height in cells.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a check; accepted only when idle.
REQ-006 SHALL have ports anchor_row, anchor_col  input  5 each  anchor cell, unsigned.
REQ-007 SHALL have ports blk1..blk4_voffset, blk1..blk4_hoffset  input  5 each  shaper offsets, two's complement.
REQ-008 SHALL have port busy  output  1  check in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port collide  output  1  result: a block is out of bounds or on an occupied cell.
REQ-011 SHALL have port oob  output  1  result: a block is outside the board.
REQ-012 SHALL have ports rd_en  output  1,  rd_row  output  5,  rd_col  output  5  board read request.
REQ-013 SHALL have port rd_data  input  1  cell occupancy, valid the cycle after rd_en.

Function
REQ-014 SHALL implement states IDLE, ISSUE, EVAL, DONE and a 2-bit block index k (blocks 1..4).
REQ-015 IDLE: on start=1, SHALL capture the anchor and all 8 offsets, clear collide/oob, set k=1, and enter ISSUE.
REQ-016 Cell coordinates SHALL be row = anchor_row + voffset[k] and col = anchor_col + hoffset[k], 5-bit modulo 32.
REQ-017 A cell SHALL be out of bounds when row >= BOARD_H or col >= BOARD_W; negative results wrap to large values and so count as out of bounds.
REQ-018 ISSUE: for an in-bounds cell, SHALL drive rd_en=1 with rd_row/rd_col; for an out-of-bounds cell, rd_en SHALL stay 0 and the OOB flag is latched; SHALL then enter EVAL.
REQ-019 EVAL: SHALL set oob if the cell was out of bounds, and set collide if the cell was out of bounds or rd_data=1; sticky until the next accepted start.
REQ-020 EVAL: when k=4, SHALL go to DONE; otherwise SHALL increment k and return to ISSUE.
REQ-021 DONE: done=1 for exactly one cycle; SHALL then return to IDLE.
REQ-022 busy SHALL be 1 in ISSUE, EVAL and DONE, and 0 in IDLE.
REQ-023 start SHALL be ignored while busy=1; captured inputs SHALL not change mid-check.
REQ-024 Latency (full walk): start sampled at edge 0; block k ISSUE in cycle 2k-1, EVAL in cycle 2k; done in cycle 9.
REQ-025 collide and oob SHALL hold their values after done until the next accepted start.
REQ-026 rd_row/rd_col SHALL be 0 whenever rd_en=0.
REQ-027 Duplicate cells (identical offsets) SHALL each be checked independently, with no error.

Reset
REQ-028 When rst=1 at a posedge, SHALL enter IDLE with k=1 and busy, done, collide, oob, rd_en, rd_row, rd_col all 0.
REQ-029 Reset mid-check SHALL abort the check with no done pulse; rst SHALL take priority over start.

Configuration
REQ-030 Macro TETRON_EARLY_EXIT_EN defined: EVAL finding a collision SHALL go directly to DONE, so done falls in cycle 2k+1 for the first colliding block k.
REQ-031 Macro TETRON_EARLY_EXIT_EN undefined: all 4 blocks SHALL always be walked and done SHALL always fall in cycle 9.

Verification
REQ-032 Empty board, anchor (5,4), offsets (0,0),(0,1),(0,31),(1,0) -> rd_en 4 times at (5,4),(5,5),(5,3),(6,4); done cycle 9; collide=0, oob=0.
REQ-033 Same offsets, anchor (5,0) -> block 3 col=31, no rd_en in cycle 5; oob=1, collide=1; done cycle 9, or cycle 7 with early exit.
REQ-034 Cell (5,5) occupied, anchor (5,4) -> collide=1, oob=0; done cycle 5 with TETRON_EARLY_EXIT_EN defined, cycle 9 without.
REQ-035 Anchor (19,4) with offset (1,0) -> row 20 >= BOARD_H; oob=1, collide=1.
REQ-036 start repeated in cycles 1..8 with a different anchor -> ignored; result matches the first anchor; exactly one done.
REQ-037 rst=1 in cycle 4 -> busy=0 and all outputs 0 next cycle; no done; a fresh start then completes normally.
